// File: rtl/traffic_pkg.sv
// traffic_pkg: state codes, lamp encodings and direction constants shared by the intersection controller.
package traffic_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_A  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    ALLRED_B  = 3'd6,
    WALK      = 3'd7
  } state_t;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;
  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;
endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// phase_timer: saturating tick counter for the current phase; clear wins over increment.
module phase_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (tick && cnt != '1) cnt <= cnt + W'(1);
endmodule

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: two-approach signal controller with demand-actuated greens, all-red clearance and a pedestrian walk phase.
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int CNT_W       = 6,
  parameter int T_GREEN     = 20,
  parameter int T_MIN_GREEN = 5,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 2,
  parameter int T_WALK      = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       en,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       ped_req,
  output logic       ped_ack,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] state_o
);
  localparam logic [CNT_W-1:0] C_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] C_MIN    = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] C_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] C_ALLRED = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] C_WALK   = CNT_W'(T_WALK - 1);

  if (T_MIN_GREEN < 1 || T_MIN_GREEN > T_GREEN || T_YELLOW < 1 || T_ALLRED < 1 || T_WALK < 1 ||
      T_GREEN > 2**CNT_W || T_YELLOW > 2**CNT_W || T_ALLRED > 2**CNT_W || T_WALK > 2**CNT_W) begin : g_bad_params
    $error("intersection_scheduler: illegal timing parameters");
  end

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             ped_pend, next_dir, clr, to_walk, ns_go, ew_go;

  phase_timer #(.W(CNT_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .clr  (clr),
    .cnt  (cnt)
  );

  // A green yields early only when its own approach has gone quiet; otherwise it runs to full length.
  always_comb begin
    ns_go   = !en || ((ew_req || ped_pend) && ((cnt >= C_MIN && !ns_req) || cnt >= C_GREEN));
    ew_go   = !en || ((ns_req || ped_pend) && ((cnt >= C_MIN && !ew_req) || cnt >= C_GREEN));
    state_n = state;
    case (state)
      IDLE:      if (tick && en) state_n = ALLRED_B;
      NS_GREEN:  if (tick && ns_go) state_n = NS_YELLOW;
      NS_YELLOW: if (tick && cnt == C_YELLOW) state_n = ALLRED_A;
      ALLRED_A:  if (tick && cnt == C_ALLRED) state_n = !en ? IDLE : ped_pend ? WALK : EW_GREEN;
      EW_GREEN:  if (tick && ew_go) state_n = EW_YELLOW;
      EW_YELLOW: if (tick && cnt == C_YELLOW) state_n = ALLRED_B;
      ALLRED_B:  if (tick && cnt == C_ALLRED) state_n = !en ? IDLE : ped_pend ? WALK : NS_GREEN;
      WALK:      if (tick && cnt == C_WALK) state_n = !en ? IDLE : next_dir == DIR_EW ? EW_GREEN : NS_GREEN;
      default:   state_n = IDLE;
    endcase
    clr     = state_n != state;
    to_walk = state_n == WALK && state != WALK;
  end

  // A request coinciding with WALK entry is served by that walk, so clearing wins.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      ped_pend <= 1'b0;
      ped_ack  <= 1'b0;
      next_dir <= DIR_NS;
    end else begin
      state    <= state_n;
      ped_pend <= to_walk ? 1'b0 : ped_pend | ped_req;
      ped_ack  <= to_walk;
      if (to_walk) next_dir <= state == ALLRED_A ? DIR_EW : DIR_NS;
    end

  assign ns_light = state == NS_GREEN ? GRN : state == NS_YELLOW ? YEL : RED;
  assign ew_light = state == EW_GREEN ? GRN : state == EW_YELLOW ? YEL : RED;
  assign walk     = state == WALK;
  assign state_o  = state;
endmodule

// File: tb/tb_intersection_scheduler.sv
// tb_intersection_scheduler: directed scenarios checked every cycle against a phase-level model, plus literal phase-length checks.
module tb_intersection_scheduler;
  import traffic_pkg::*;
  localparam int TG = 20, TM = 5, TY = 3, TA = 2, TW = 10;

  logic clk = 0, rst = 1, tick = 0, en = 0, ns_req = 0, ew_req = 0, ped_req = 0;
  logic ped_ack, walk;
  logic [2:0] ns_light, ew_light, state_o;
  int compared = 0, mismatched = 0, period = 4, ack_count = 0;

  intersection_scheduler #(
    .CNT_W(6), .T_GREEN(TG), .T_MIN_GREEN(TM), .T_YELLOW(TY), .T_ALLRED(TA), .T_WALK(TW)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .en(en), .ns_req(ns_req), .ew_req(ew_req),
    .ped_req(ped_req), .ped_ack(ped_ack), .ns_light(ns_light), .ew_light(ew_light),
    .walk(walk), .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    int d = 0;
    forever begin
      @(posedge clk);
      #2;
      d = (d + 1) % period;
      tick = (d == 0);
    end
  end

  // Model: phase identity plus how many ticks of that phase have already elapsed.
  logic [2:0] m_st = IDLE;
  int m_el = 0;
  bit m_pend = 0, m_dir = 0, m_ack = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_st = IDLE; m_el = 0; m_pend = 0; m_dir = 0; m_ack = 0;
    end else begin
      logic [2:0] nxt;
      int nth;
      nxt = m_st;
      nth = m_el + 1;
      if (tick)
        case (m_st)
          IDLE:      if (en) nxt = ALLRED_B;
          NS_GREEN:  if (!en || ((ew_req || m_pend) && ((nth >= TM && !ns_req) || nth >= TG))) nxt = NS_YELLOW;
          EW_GREEN:  if (!en || ((ns_req || m_pend) && ((nth >= TM && !ew_req) || nth >= TG))) nxt = EW_YELLOW;
          NS_YELLOW: if (nth == TY) nxt = ALLRED_A;
          EW_YELLOW: if (nth == TY) nxt = ALLRED_B;
          ALLRED_A:  if (nth == TA) nxt = !en ? IDLE : m_pend ? WALK : EW_GREEN;
          ALLRED_B:  if (nth == TA) nxt = !en ? IDLE : m_pend ? WALK : NS_GREEN;
          default:   if (nth == TW) nxt = !en ? IDLE : m_dir ? EW_GREEN : NS_GREEN;
        endcase
      m_ack = nxt == WALK && m_st != WALK;
      if (m_ack) begin m_dir = (m_st == ALLRED_A); m_pend = 0; end
      else if (ped_req) m_pend = 1;
      m_el = (nxt != m_st) ? 0 : m_el + int'(tick);
      m_st = nxt;
    end
  end

  function automatic logic [2:0] head(input logic [2:0] st, input bit ew);
    if (st == (ew ? EW_GREEN : NS_GREEN)) return 3'b001;
    if (st == (ew ? EW_YELLOW : NS_YELLOW)) return 3'b010;
    return 3'b100;
  endfunction

  initial forever begin
    @(negedge clk);
    compared++;
    if ({ns_light, ew_light, walk, ped_ack, state_o} !==
        {head(m_st, 0), head(m_st, 1), m_st == WALK, m_ack, m_st}) begin
      mismatched++;
      $display("FAIL cycle @%0t: dut ns=%b ew=%b walk=%b ack=%b st=%0d, model ns=%b ew=%b walk=%b ack=%b st=%0d",
               $time, ns_light, ew_light, walk, ped_ack, state_o,
               head(m_st, 0), head(m_st, 1), m_st == WALK, m_ack, m_st);
    end
  end

  initial forever begin
    @(negedge clk);
    if (ped_ack === 1'b1) ack_count++;
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input string name);
    int n = 0;
    while (state_o !== st && n < 2000) begin @(negedge clk); n++; end
    chk({name, " reached"}, int'(state_o), int'(st));
  endtask

  task automatic measure(input logic [2:0] st, input string name, input int want);
    int n = 0, t = 0;
    wait_state(st, name);
    while (state_o === st && t < 5000) begin
      if (tick) n++;
      @(negedge clk);
      t++;
    end
    chk(name, n, want);
  endtask

  initial begin
    int k;
    repeat (2) @(negedge clk);
    chk("reset state", int'(state_o), 0);
    chk("reset ns", int'(ns_light), 4);
    chk("reset ew", int'(ew_light), 4);
    chk("reset walk", int'(walk), 0);
    chk("reset ack", int'(ped_ack), 0);
    rst = 0; en = 1;
    measure(ALLRED_B, "startup allred", 2);
    chk("startup ns green", int'(ns_light), 1);
    repeat (100 * 4) @(negedge clk);
    chk("resting ns green", int'(ns_light), 1);
    chk("no ack while resting", ack_count, 0);

    ew_req = 1;
    measure(NS_YELLOW, "yellow after rest", 3);
    measure(ALLRED_A, "allred a", 2);
    chk("ew green", int'(ew_light), 1);
    ns_req = 1; ew_req = 0;
    wait_state(EW_YELLOW, "ew yields");
    ns_req = 0; ew_req = 1;
    measure(NS_GREEN, "min green", 5);
    measure(NS_YELLOW, "yellow after min", 3);
    measure(ALLRED_A, "allred after min", 2);

    ns_req = 1; ew_req = 1;
    measure(EW_GREEN, "full ew green", 20);
    measure(EW_YELLOW, "ew yellow", 3);
    measure(ALLRED_B, "allred b", 2);
    measure(NS_GREEN, "full ns green", 20);
    measure(NS_YELLOW, "ns yellow", 3);
    measure(ALLRED_A, "allred a again", 2);
    measure(EW_GREEN, "full ew green again", 20);

    ns_req = 0; ew_req = 1;
    wait_state(NS_GREEN, "ns before ped");
    ped_req = 1; @(negedge clk); ped_req = 0;
    measure(NS_YELLOW, "yellow before walk", 3);
    wait_state(ALLRED_A, "allred before walk");
    k = 0;
    while (k < TA) begin
      if (tick) k++;
      if (k < TA) @(negedge clk);
    end
    ped_req = 1; @(negedge clk); ped_req = 0;
    chk("walk entered", int'(state_o), int'(WALK));
    chk("ack on walk entry", int'(ped_ack), 1);
    chk("walk lamp", int'(walk), 1);
    measure(WALK, "walk length", 10);
    chk("ew after walk", int'(ew_light), 1);
    chk("single ack", ack_count, 1);

    ns_req = 1; ew_req = 0;
    measure(ALLRED_B, "allred after walk", 2);
    chk("no second walk", int'(state_o), int'(NS_GREEN));
    chk("ack count unchanged", ack_count, 1);

    repeat (8) @(negedge clk);
    en = 0;
    measure(NS_YELLOW, "en drop yellow", 3);
    measure(ALLRED_A, "en drop allred", 2);
    chk("idle after en drop", int'(state_o), int'(IDLE));

    en = 1; ns_req = 0; ew_req = 1;
    wait_state(NS_YELLOW, "yellow before reset");
    repeat (4) @(negedge clk);
    #1 rst = 1;
    #1;
    chk("async reset ns", int'(ns_light), 4);
    chk("async reset ew", int'(ew_light), 4);
    chk("async reset state", int'(state_o), 0);
    @(negedge clk);
    rst = 0;

    period = 1;
    measure(ALLRED_B, "continuous allred", 2);
    measure(NS_GREEN, "continuous min green", 5);
    measure(NS_YELLOW, "continuous yellow", 3);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/intersection_scheduler.md
# intersection_scheduler

Two-approach intersection controller that sequences north-south (NS) and east-west (EW) signal heads plus a shared pedestrian walk phase. Sits above the single-head light sequencer and the frequency divider: it consumes a one-clock `tick` enable from the divider and drives both heads and the walk lamp. It adds demand-actuated green termination, all-red clearance and a latched pedestrian request/acknowledge handshake.

## Interface
- `CNT_W`, 6: phase counter width; must hold max(T_*)−1.
- `T_GREEN`, 20: nominal green length, ticks.
- `T_MIN_GREEN`, 5: minimum green before early termination, ticks; 1 ≤ T_MIN_GREEN ≤ T_GREEN.
- `T_YELLOW`, 3: yellow length, ticks.
- `T_ALLRED`, 2: all-red clearance length, ticks.
- `T_WALK`, 10: pedestrian walk length, ticks.
- All T_* values ≥ 1.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-clk timing enable from the divider; all phase timing counts ticks.
- `en`  in  1  run enable, level.
- `ns_req`  in  1  NS vehicle detector, level.
- `ew_req`  in  1  EW vehicle detector, level.
- `ped_req`  in  1  pedestrian button, sampled every clk.
- `ped_ack`  out  1  one-clk pulse when the walk phase is granted.
- `ns_light`  out  3  {R,Y,G} for the NS head.
- `ew_light`  out  3  {R,Y,G} for the EW head.
- `walk`  out  1  walk lamp.
- `state_o`  out  3  current state code, for debug.

## Operation
- States: IDLE, NS_GREEN, NS_YELLOW, ALLRED_A (after NS), EW_GREEN, EW_YELLOW, ALLRED_B (after EW), WALK.
- Moore outputs decoded from the state register.
  - IDLE, ALLRED_*, WALK: both heads 100.
  - NS_GREEN: NS 001, EW 100. NS_YELLOW: NS 010, EW 100.
  - EW states mirror the NS states.
  - `walk` = 1 only in WALK.
- `cnt` clears to 0 on every state entry. On each tick with no exit, `cnt` increments, saturating at 2^CNT_W−1.
- Transitions are evaluated only on clk edges where `tick` = 1. "Expired(T)" means `cnt` == T−1 on a tick.
- IDLE → ALLRED_B on a tick with `en` = 1, so NS is served first.
- X_GREEN exits to X_YELLOW on a tick when any of the following holds:
  - (a) `en` = 0;
  - (b) `cnt` ≥ T_MIN_GREEN−1 and opposing req or `ped_pend` is set, and own req = 0;
  - (c) `cnt` ≥ T_GREEN−1 and opposing req or `ped_pend` is set.
  - With no conflicting demand, the head rests on green indefinitely.
- X_YELLOW → ALLRED after Expired(T_YELLOW).
- ALLRED_A / ALLRED_B after Expired(T_ALLRED):
  - `en` = 0 → IDLE;
  - else `ped_pend` → WALK;
  - else the next green: EW after ALLRED_A, NS after ALLRED_B.
- `next_dir` register records which green follows a WALK.
- WALK after Expired(T_WALK): `en` = 0 → IDLE, else green of `next_dir`.
- Pedestrian handshake:
  - `ped_pend` is set on any clk with `ped_req` = 1.
  - `ped_pend` clears on the clk that enters WALK. A `ped_req` arriving on that same clk counts as served and does not re-set `ped_pend`.
  - `ped_ack` is registered and high for exactly the first clk of WALK.
- Illegal state code → IDLE on the next clk.

## Timing
- Reset values:
  - state IDLE, `cnt` 0, `ped_pend` 0, `next_dir` NS;
  - `ns_light` = `ew_light` = 100, `walk` 0, `ped_ack` 0, `state_o` 0.
- Reset asserted mid-phase: outputs go to all-red immediately (asynchronous); pending request lost.
- Output latency: state change on a tick edge; lights update in the same clk (Moore decode), with no extra register stage.
- A timed phase of length T occupies exactly T ticks.
- Green occupies at least T_MIN_GREEN ticks whenever entered with `en` = 1.
- `tick` held high continuously is legal and makes phases last T clks.
- `en` deassert: the head completes yellow + all-red before IDLE; a head is never cut from green straight to red.

## Structure
- Package `traffic_pkg`: state enum with codes IDLE=0, NS_GREEN=1, NS_YELLOW=2, ALLRED_A=3, EW_GREEN=4, EW_YELLOW=5, ALLRED_B=6, WALK=7; light constants RED=100, YEL=010, GRN=001, OFF=000.
- One sub-module, `phase_timer`: `clk`, `rst`, `tick`, `clr`, `cnt` out; clear has priority over increment; saturating.
- Parameter legality checked by elaboration-time assertions.

## Test plan
- Reset, then `en` = 1 with `tick` every 4 clks and no demand → after 2 ticks NS green; stays NS 001 for 100 ticks; `ped_ack` never pulses.
- `ew_req` = 1 steady, `ns_req` = 0 → NS green ends after 5 ticks; 3 ticks yellow, 2 all-red, then EW 001.
- `ns_req` = `ew_req` = 1 → NS green 20 ticks, yellow 3, all-red 2, EW green 20; this cycle repeats.
- `ped_req` pulse during NS green with `ew_req` = 1 → WALK after ALLRED_A; `ped_ack` high for 1 clk; `walk` = 1 for 10 ticks; then EW green.
- `ped_req` asserted on the clk WALK is entered → no second WALK in the following cycle.
- `en` dropped mid NS green → yellow 3 ticks, all-red 2 ticks, IDLE. Async `rst` pulse mid-yellow → all heads 100 before the next clk edge.
